// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one dual-clock FIFO write port among NREQ requesters.
// Optional error counter (err_cnt port) is built only when WARB_ERRCNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  input  logic                  wfull_almost
`ifdef WARB_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LW-1:0]     last_q, last_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              thr_q, thr_d;

  logic [LW-1:0]     gidx;
  logic              sel_vld;
  logic [LW-1:0]     pick;
  logic              found;

  // Index of the current grant holder, plus its data slice on the write port.
  always_comb begin
    gidx  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gidx  = LW'(i);
        wdata = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign sel_vld = req_valid[gidx];
  assign busy    = (state_q == S_GRANT);
  assign grant   = grant_q;
  assign winc    = busy & sel_vld & ~wfull & ~thr_q;
  assign req_ack = {NREQ{winc}} & grant_q;

  // Round-robin search starting just above the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = LW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    thr_d   = winc & wfull_almost;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          bcnt_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!sel_vld || (winc && bcnt_q == BW'(BURST - 1))) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx;
        end else if (winc) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NREQ - 1);
      bcnt_q  <= '0;
      thr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      thr_q   <= thr_d;
    end
  end

`ifdef WARB_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       viol, abandon;

  // Writes into a full FIFO, or a holder walking away mid-burst.
  assign viol    = winc & wfull;
  assign abandon = busy & ~sel_vld & (bcnt_q != '0) & (bcnt_q < BW'(BURST));

  always_comb begin
    err_d = err_q;
    if ((viol || abandon) && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) err_q <= '0;
    else         err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  // No error counter in this build.
`endif

endmodule
